// File: rtl/instr_seq_ctrl.sv
// Fixed 8-slot instruction sequencer: owns the PC, latches and classifies each
// instruction, and decodes regfile/ALU/DM strobes from the current frame slot.
module instr_seq_ctrl #(
  parameter int DataSize = 32,
  parameter int MemSize  = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DataSize-1:0] instruction,
  output logic [MemSize-1:0]  PC,
  output logic                IM_read,
  output logic                IM_write,
  output logic                IM_enable,
  output logic                DM_read,
  output logic                DM_write,
  output logic                DM_enable,
  output logic [DataSize-1:0] ir,
  output logic                reg_read,
  output logic                reg_write,
  output logic                alu_en,
  output logic                imm_sel,
  output logic                mem_to_reg,
  output logic                illegal,
  output logic [2:0]          state,
  output logic [127:0]        cycle_cnt
);

  typedef enum logic [2:0] {
    S_FETCH, S_WAIT, S_LATCH, S_DECODE, S_EXEC, S_MEM, S_MEMWAIT, S_WB
  } slot_e;

  typedef enum logic [2:0] {
    C_ALU, C_IMM, C_MOVI, C_LW, C_SW, C_ILL
  } class_e;

  slot_e               state_q, state_d;
  class_e              cls_q, cls_d;
  logic [MemSize-1:0]  pc_q, pc_d;
  logic [DataSize-1:0] ir_q, ir_d;
  logic [127:0]        cnt_q;

  function automatic class_e classify(input logic [5:0] op);
    unique case (op)
      6'b100000:                       return C_ALU;
      6'b101000, 6'b101100, 6'b101011: return C_IMM;
      6'b100010:                       return C_MOVI;
      6'b000010:                       return C_LW;
      6'b001010:                       return C_SW;
      default:                         return C_ILL;
    endcase
  endfunction

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      cls_q   <= C_ILL;
      pc_q    <= '0;
      ir_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_q + 128'd1;
    end
  end

  always_comb begin
    // NOTE: every signal written here gets a default first, so no branch
    // of the case below can leave one unassigned and infer a latch.
    state_d    = S_FETCH;
    cls_d      = cls_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    IM_read    = 1'b0;
    IM_enable  = 1'b0;
    DM_read    = 1'b0;
    DM_write   = 1'b0;
    DM_enable  = 1'b0;
    reg_read   = 1'b0;
    reg_write  = 1'b0;
    alu_en     = 1'b0;
    imm_sel    = 1'b0;
    mem_to_reg = 1'b0;
    illegal    = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        state_d   = S_WAIT;
        IM_enable = 1'b1;
        IM_read   = 1'b1;
      end
      S_WAIT: begin
        state_d   = S_LATCH;
        IM_enable = 1'b1;
      end
      S_LATCH: begin
        state_d = S_DECODE;
        ir_d    = instruction;
        cls_d   = classify(instruction[30:25]);
      end
      S_DECODE: begin
        state_d  = S_EXEC;
        reg_read = (cls_q != C_ILL);
      end
      S_EXEC: begin
        state_d = S_MEM;
        alu_en  = (cls_q inside {C_ALU, C_IMM});
      end
      S_MEM: begin
        state_d   = S_MEMWAIT;
        DM_enable = (cls_q inside {C_LW, C_SW});
        DM_read   = (cls_q == C_LW);
        DM_write  = (cls_q == C_SW);
      end
      S_MEMWAIT: begin
        state_d    = S_WB;
        DM_enable  = (cls_q == C_LW);
        mem_to_reg = (cls_q == C_LW);
      end
      S_WB: begin
        state_d    = S_FETCH;
        pc_d       = pc_q + MemSize'(1);
        mem_to_reg = (cls_q == C_LW);
        reg_write  = (cls_q inside {C_ALU, C_IMM, C_MOVI, C_LW});
        illegal    = (cls_q == C_ILL);
      end
      default: ;
    endcase

    // The class register holds the previous frame until S2, so imm_sel waits for S3.
    imm_sel = (state_q >= S_DECODE) && (cls_q inside {C_IMM, C_MOVI, C_LW, C_SW});

    if (reset) begin
      IM_read    = 1'b0;
      IM_enable  = 1'b0;
      DM_read    = 1'b0;
      DM_write   = 1'b0;
      DM_enable  = 1'b0;
      reg_read   = 1'b0;
      reg_write  = 1'b0;
      alu_en     = 1'b0;
      imm_sel    = 1'b0;
      mem_to_reg = 1'b0;
      illegal    = 1'b0;
    end
  end

  assign PC        = pc_q;
  assign ir        = ir_q;
  assign state     = state_q;
  assign cycle_cnt = cnt_q;
  assign IM_write  = 1'b0;

endmodule

// File: doc/instr_seq_ctrl.md
Name: instr_seq_ctrl

Overview:
- Multi-cycle sequencer for the single-issue 32-bit core. It drives the IM fetch port and owns the PC.
- Latches and classifies each instruction, then issues strobes to the regfile, ALU and DM port in a fixed 8-cycle instruction frame.
- Sits inside top beside regfile1 and the ALU, replacing hand-wired control. It also keeps the 128-bit cycle counter that top exports.

Parameters:
- DataSize, 32, instruction/data width
- MemSize, 10, PC width (IM word address)

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- instruction  in  DataSize  IMout, valid from the 2nd cycle after IM_read
- PC  out  MemSize  IM word address
- IM_read  out  1  fetch strobe
- IM_write  out  1  IM write enable, tied 0
- IM_enable  out  1  IM chip enable
- DM_read  out  1  DM fetch strobe
- DM_write  out  1  DM write strobe
- DM_enable  out  1  DM chip enable
- ir  out  DataSize  latched instruction register
- reg_read  out  1  regfile read-port enable
- reg_write  out  1  regfile write enable
- alu_en  out  1  ALU result-register load
- imm_sel  out  1  1 = operand B is the immediate
- mem_to_reg  out  1  1 = writeback source is DM_out
- illegal  out  1  unknown-opcode flag, one-cycle pulse
- state  out  3  current frame slot, for debug
- cycle_cnt  out  128  cycles since reset deassert

Behaviour:
- Reset (reset=1 at a clk edge): state=S0, PC=0, ir=0, cycle_cnt=0, all strobes=0. Reset mid-frame aborts the frame; no reg_write or DM_write is issued for it.
- Frame slots. State advances S0..S7 and then back to S0 every cycle when reset=0; there is no stall. Every instruction takes exactly 8 cycles.
  - S0 FETCH: IM_enable=1, IM_read=1.
  - S1 WAIT: IM_enable=1.
  - S2 LATCH: ir<=instruction at the end of S2.
  - S3 DECODE: reg_read=1.
  - S4 EXEC: alu_en=1 for ALU-class and IMM-class.
  - S5 MEM: DM_enable=1. DM_read=1 for LW; DM_write=1 for SW.
  - S6 MEMWAIT: DM_enable=1 for LW.
  - S7 WB: reg_write=1 for ALU, IMM, MOVI and LW. PC<=PC+1, wrapping 2^MemSize-1 -> 0.
- Classification uses ir[30:25], registered in S2 and held through S7:
  - 6'b100000 ALU: ADD/SUB/AND/OR/XOR/SRLI/SLLI/ROTRI; subop decoded by the ALU. NOP is an ALU encoding and writes R0 unchanged.
  - 6'b101000 ADDI, 6'b101100 ORI, 6'b101011 XORI: IMM-class, imm_sel=1 in S3–S7.
  - 6'b100010 MOVI: imm_sel=1; ALU passes the immediate.
  - 6'b000010 LW: imm_sel=1 (address calc), mem_to_reg=1 in S6–S7.
  - 6'b001010 SW: imm_sel=1, no reg_write.
  - Any other opcode: no DM, ALU or regfile strobes. illegal=1 during S7 only. PC still advances.
- IM_write is always 0. DM_read and DM_write are never both 1.
- cycle_cnt increments by 1 on every clk edge with reset=0 and wraps modulo 2^128.
- PC is held throughout S0–S6. PC, ir and state are all registered outputs; strobes are decoded from the registered state and class.

Test Plan:
- Reset held 3 cycles, then released → state=0, PC=0, cycle_cnt=0; after 8 cycles PC=1 and cycle_cnt=8.
- MOVI R0,200 followed by NOP → IM_read high in S0 only; reg_write high in S7 of both frames; imm_sel=1 only in the MOVI frame; DM strobes never asserted.
- SW R0→M0 then LW R2←M0 → SW frame: DM_write=1 in S5, reg_write=0 in S7. LW frame: DM_read=1 in S5, mem_to_reg=1 in S6–S7, reg_write=1 in S7.
- Program of 24 instructions (mins2 sequence) → PC=24 after 192 cycles past reset release; cycle_cnt=192; final mem/reg values match the golden table (M8=0x8000000C, R4=0).
- ir[30:25]=6'b111111 → illegal=1 for exactly one cycle (S7); no reg_write, alu_en or DM strobes; PC increments.
- reset asserted during S5 of a SW frame → DM_write=0 from the next edge onward; restart at S0 with PC=0. Separately, preload PC=1023 by running → wraps to 0 after S7.
